sseg_capture: RTL

SSEG_CAPTURE -- requirements
Module: sseg_capture

---
 rtl/sseg_capture.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/sseg_capture.sv
// Seven-segment display scanner capture.
// Samples a multiplexed active-low segment bus and digit select, waits for each digit's
// pattern to be stable for STABLE samples, decodes it to a hex nibble and assembles
// DIGITS nibbles into a word offered on a valid/ready output.
module sseg_capture #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned STABLE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_n,
  input  logic [DIGITS-1:0]     dig_sel,
  output logic [4*DIGITS-1:0]   word,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic                  err,
  output logic                  overrun
);

  typedef enum logic [1:0] {StIdle, StCount, StDone} state_e;

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [6:0]            seg_q, prev_seg_q;
  logic [DIGITS-1:0]     sel_q, prev_sel_q;
  logic [4*DIGITS-1:0]   slots_q, slots_d;
  logic [DIGITS-1:0]     cap_q, cap_d;
  logic [4*DIGITS-1:0]   word_q, word_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic                  ovr_q, ovr_d;

  logic                  sel_onehot;
  logic                  same;
  logic                  commit;
  logic [6:0]            pat;
  logic [3:0]            nib;
  logic                  legal;

  assign sel_onehot = (sel_q != '0) && ((sel_q & (sel_q - 1'b1)) == '0);
  // Current sample compared against the one taken a cycle earlier.
  assign same       = (seg_q == prev_seg_q) && (sel_q == prev_sel_q);

  // Decode the active-high glyph into a hex nibble.
  always_comb begin
    pat   = ~seg_q;
    nib   = 4'h0;
    legal = 1'b1;
    case (pat)
      7'h3F: nib = 4'h0;
      7'h06: nib = 4'h1;
      7'h5B: nib = 4'h2;
      7'h4F: nib = 4'h3;
      7'h66: nib = 4'h4;
      7'h6D: nib = 4'h5;
      7'h7D: nib = 4'h6;
      7'h07: nib = 4'h7;
      7'h7F: nib = 4'h8;
      7'h6F: nib = 4'h9;
      7'h77: nib = 4'hA;
      7'h7C: nib = 4'hB;
      7'h39: nib = 4'hC;
      7'h5E: nib = 4'hD;
      7'h79: nib = 4'hE;
      7'h71: nib = 4'hF;
      default: legal = 1'b0;
    endcase
  end

  // Stability FSM: counts identical one-hot samples and commits once per stable run.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      StIdle: begin
        if (sel_onehot) begin
          state_d = StCount;
          cnt_d   = 8'd1;
        end else begin
          cnt_d   = 8'd0;
        end
      end
      StCount: begin
        if (!sel_onehot) begin
          state_d = StIdle;
          cnt_d   = 8'd0;
        end else if (!same) begin
          cnt_d   = 8'd1;
        end else if (cnt_q >= 8'(STABLE - 1)) begin
          // Counter saturates at STABLE; the commit happens on the edge it gets there.
          cnt_d   = 8'(STABLE);
          commit  = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d   = cnt_q + 8'd1;
        end
      end
      StDone: begin
        if (!sel_onehot) begin
          state_d = StIdle;
          cnt_d   = 8'd0;
        end else if (!same) begin
          state_d = StCount;
          cnt_d   = 8'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Slot update, word transfer/discard and status flags.
  always_comb begin
    slots_d = slots_q;
    cap_d   = cap_q;
    word_d  = word_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    err_d   = 1'b0;
    if (valid_q && word_ready) valid_d = 1'b0;
    if (&cap_q) begin
      cap_d = '0;
      if (!valid_q || word_ready) begin
        word_d  = slots_q;
        valid_d = 1'b1;
      end else begin
        ovr_d   = 1'b1;
      end
    end
    // Applied after the clear so a same-edge commit seeds the next capture.
    if (commit) begin
      if (legal) begin
        for (int unsigned i = 0; i < DIGITS; i++) begin
          if (sel_q[i]) slots_d[4*i +: 4] = nib;
        end
        cap_d = cap_d | sel_q;
      end else begin
        cap_d = cap_d & ~sel_q;
        err_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      seg_q      <= '0;
      sel_q      <= '0;
      prev_seg_q <= '0;
      prev_sel_q <= '0;
      slots_q    <= '0;
      cap_q      <= '0;
      word_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      seg_q      <= seg_n;
      sel_q      <= dig_sel;
      prev_seg_q <= seg_q;
      prev_sel_q <= sel_q;
      slots_q    <= slots_d;
      cap_q      <= cap_d;
      word_q     <= word_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      ovr_q      <= ovr_d;
    end
  end

  assign word       = word_q;
  assign word_valid = valid_q;
  assign err        = err_q;
  assign overrun    = ovr_q;

endmodule
